// File: rtl/fifo_unpacker_pkg.sv
// Shared FIFO-adapter definitions: wide/narrow ratio, beat-counter width and
// the order in which slices of a wide word are emitted.
package fifo_unpacker_pkg;

    // Beat 0 is the least-significant slice of the held word.
    localparam bit SLICE_LSB_FIRST = 1'b1;

    function automatic int ratio_of(input int wide_w, input int narrow_w);
        return wide_w / narrow_w;
    endfunction

    function automatic int cnt_w_of(input int ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Splits each wide word popped from an upstream FIFO into RATIO narrow beats
// on a valid/ready stream, reloading on the last beat so words run gap-free.
module fifo_unpacker
    import fifo_unpacker_pkg::*;
#(
    parameter int WIDE_W   = 32,
    parameter int NARROW_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    input  logic                EMPTY_N,
    input  logic [WIDE_W-1:0]   D_OUT,
    output logic                DEQ,
    output logic                OUT_VALID,
    output logic [NARROW_W-1:0] OUT_DATA,
    output logic                OUT_LAST,
    input  logic                OUT_READY,
    output logic                BUSY
);

    localparam int RATIO = ratio_of(WIDE_W, NARROW_W);
    localparam int CNT_W = cnt_w_of(RATIO);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    generate
        if ((WIDE_W % NARROW_W) != 0 || RATIO < 2) begin : g_param_err
            $fatal(1, "fifo_unpacker: WIDE_W must be a multiple (>=2x) of NARROW_W");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [WIDE_W-1:0]  hold_q, hold_d;

    logic               hold_valid;
    logic               last_beat;
    logic               deq;
    logic [CNT_W-1:0]   slice_idx;

    assign hold_valid = (state_q == SEND);
    assign last_beat  = hold_valid && (beat_q == LAST_BEAT);
    assign slice_idx  = SLICE_LSB_FIRST ? beat_q : (LAST_BEAT - beat_q);

    // Pull a new word when empty-handed or when the last beat is leaving now.
    assign deq = EMPTY_N && !CLR && !RST && (!hold_valid || (OUT_READY && last_beat));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        if (CLR) begin
            state_d = IDLE;
            beat_d  = '0;
            hold_d  = '0;
        end else if (deq) begin
            state_d = SEND;
            beat_d  = '0;
            hold_d  = D_OUT;
        end else if (hold_valid && OUT_READY) begin
            if (last_beat) begin
                state_d = IDLE;
                beat_d  = '0;
            end else begin
                beat_d  = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs are masked during reset so the first reset cycle is already quiet.
    assign DEQ       = deq;
    assign OUT_VALID = hold_valid && !RST;
    assign OUT_LAST  = last_beat && !RST;
    assign OUT_DATA  = RST ? '0 : hold_q[slice_idx*NARROW_W +: NARROW_W];
    assign BUSY      = OUT_VALID;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Scoreboard bench: upstream FIFO modelled as a word queue, each popped word
// expands into expected beats checked whenever the DUT presents a beat.
module tb_fifo_unpacker;

    localparam int WIDE_W   = 32;
    localparam int NARROW_W = 8;
    localparam int RATIO    = WIDE_W / NARROW_W;

    typedef struct packed {
        logic [NARROW_W-1:0] d;
        logic                last;
    } beat_t;

    logic                CLK = 1'b0;
    logic                RST, CLR, EMPTY_N, OUT_READY;
    logic [WIDE_W-1:0]   D_OUT;
    logic                DEQ, OUT_VALID, OUT_LAST, BUSY;
    logic [NARROW_W-1:0] OUT_DATA;

    logic [WIDE_W-1:0] src[$];
    beat_t             exp_q[$];
    logic              fifo_en;
    logic              pop_now;
    int                checks;
    int                failures;

    fifo_unpacker #(.WIDE_W(WIDE_W), .NARROW_W(NARROW_W)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .EMPTY_N(EMPTY_N), .D_OUT(D_OUT),
        .DEQ(DEQ), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
        .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Monitor: compare at the falling edge, then advance the model to the next rising edge.
    always @(negedge CLK) begin
        logic exp_valid, exp_last, exp_deq;
        exp_valid = !RST && (exp_q.size() > 0);
        exp_last  = exp_valid && exp_q[0].last;
        exp_deq   = EMPTY_N && !CLR && !RST &&
                    ((exp_q.size() == 0) || (OUT_READY && exp_q[0].last));
        chk("deq", 32'(DEQ), 32'(exp_deq));
        chk("out_valid", 32'(OUT_VALID), 32'(exp_valid));
        chk("busy", 32'(BUSY), 32'(exp_valid));
        chk("out_last", 32'(OUT_LAST), 32'(exp_last));
        if (RST) chk("out_data_rst", 32'(OUT_DATA), 32'd0);
        else if (exp_valid) chk("out_data", 32'(OUT_DATA), 32'(exp_q[0].d));

        pop_now = exp_deq;
        if (RST || CLR) begin
            exp_q.delete();
        end else begin
            if (exp_valid && OUT_READY) void'(exp_q.pop_front());
            if (exp_deq) begin
                for (int i = 0; i < RATIO; i++)
                    exp_q.push_back('{d: D_OUT[i*NARROW_W +: NARROW_W], last: (i == RATIO - 1)});
            end
        end
    end

    // One clock: present the FIFO head, take the edge, then retire a popped word.
    task automatic cyc();
        EMPTY_N = fifo_en && (src.size() > 0);
        if (src.size() > 0) D_OUT = src[0];
        else                D_OUT = $urandom;
        @(posedge CLK);
        #1;
        if (pop_now && src.size() > 0) void'(src.pop_front());
        pop_now = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        checks = 0; failures = 0; pop_now = 1'b0;
        RST = 1'b1; CLR = 1'b0; OUT_READY = 1'b0; fifo_en = 1'b0;
        run(3);
        RST = 1'b0;
        run(2);

        // single word
        OUT_READY = 1'b1; fifo_en = 1'b1;
        src.push_back(32'hAABBCCDD);
        run(7);

        // back-to-back words
        src.push_back(32'h03020100);
        src.push_back(32'h07060504);
        run(11);

        // backpressure on beat 1
        src.push_back(32'h11223344);
        run(2);
        OUT_READY = 1'b0;
        run(3);
        OUT_READY = 1'b1;
        run(5);

        // flush after beat 1
        src.push_back(32'hDEADBEEF);
        run(3);
        CLR = 1'b1;
        run(1);
        CLR = 1'b0;
        src.push_back(32'h44332211);
        run(7);

        // reset during beat 2
        src.push_back(32'hCAFEF00D);
        run(3);
        RST = 1'b1;
        run(1);
        RST = 1'b0;
        src.push_back(32'h5A6B7C8D);
        run(7);

        // empty upstream
        fifo_en = 1'b0;
        src.push_back(32'h12345678);
        run(10);
        fifo_en = 1'b1;
        run(6);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (src.size() < 3) src.push_back($urandom);
            fifo_en   = ($urandom_range(0, 9) < 8);
            OUT_READY = ($urandom_range(0, 9) < 7);
            CLR       = ($urandom_range(0, 49) == 0);
            RST       = ($urandom_range(0, 79) == 0);
            cyc();
        end

        // drain with a bounded wait
        CLR = 1'b0; RST = 1'b0; fifo_en = 1'b0; OUT_READY = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
        run(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d beats outstanding, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
